// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its
// multiply/divide occupancy timer.
package pipe_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam int          TWIDTH       = 2;
    localparam logic [1:0]  TUSE_NONE    = 2'd3;
    localparam int          MULT_CYC_DEF = 5;
    localparam int          DIV_CYC_DEF  = 10;
    localparam int          CNT_W        = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: decode/exec operand info in,
// stall controls and multiply/divide occupancy out.
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [4:0]        rs_D;
    logic [4:0]        rt_D;
    logic [TWIDTH-1:0] tuse_rs_D;
    logic [TWIDTH-1:0] tuse_rt_D;
    logic [4:0]        writereg_E;
    logic [4:0]        writereg_M;
    logic [TWIDTH-1:0] tnew_E;
    logic [TWIDTH-1:0] tnew_M;
    logic              md_use_D;
    logic              md_start_E;
    logic              md_div_E;
    logic              pc_en;
    logic              d_en;
    logic              e_flush;
    logic              md_busy;
    logic [31:0]       stall_count;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, writereg_E, writereg_M,
               tnew_E, tnew_M, md_use_D, md_start_E, md_div_E,
        input  pc_en, d_en, e_flush, md_busy, stall_count
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, writereg_E, writereg_M,
               tnew_E, tnew_M, md_use_D, md_start_E, md_div_E,
        output pc_en, d_en, e_flush, md_busy, stall_count
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// Multiply/divide occupancy timer: a two-state FSM with a down-counter that
// reports the unit busy from the start cycle until the latency has elapsed.
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // State and counter registers; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; a start seen while BUSY is deliberately ignored
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_cnt_nxt   = is_div ? DIV_LD : MULT_LD;
                    w_state_nxt = BUSY;
                end else begin
                    w_cnt_nxt   = r_cnt;
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                w_cnt_nxt = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
                if (r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Start cycle counts as busy so a dependent D-stage op stalls immediately
    assign busy = (r_state == BUSY) | start;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: decodes RAW data hazards against E/M stages and
// multiply/divide occupancy into PC/D enables, a D/E flush and a stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic                clk,
    input  logic                reset,
    pipe_hazard_ctrl_if.slave   bus
);

    logic        w_haz_rs_e;
    logic        w_haz_rt_e;
    logic        w_haz_rs_m;
    logic        w_haz_rt_m;
    logic        w_data_stall;
    logic        w_md_busy;
    logic        w_md_stall;
    logic        w_stall;
    logic [31:0] r_stall_count;

    // A consumer stalls only when the producer result arrives after it is needed
    assign w_haz_rs_e = (bus.rs_D != 5'd0) && (bus.rs_D == bus.writereg_E) &&
                        (bus.tnew_E > bus.tuse_rs_D);
    assign w_haz_rt_e = (bus.rt_D != 5'd0) && (bus.rt_D == bus.writereg_E) &&
                        (bus.tnew_E > bus.tuse_rt_D);
    assign w_haz_rs_m = (bus.rs_D != 5'd0) && (bus.rs_D == bus.writereg_M) &&
                        (bus.tnew_M > bus.tuse_rs_D);
    assign w_haz_rt_m = (bus.rt_D != 5'd0) && (bus.rt_D == bus.writereg_M) &&
                        (bus.tnew_M > bus.tuse_rt_D);

    assign w_data_stall = w_haz_rs_e | w_haz_rt_e | w_haz_rs_m | w_haz_rt_m;
    assign w_md_stall   = bus.md_use_D & w_md_busy;
    assign w_stall      = w_data_stall | w_md_stall;

    // The E instruction is valid even when D stalls, so its start always counts
    md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (bus.md_start_E),
        .is_div (bus.md_div_E),
        .busy   (w_md_busy)
    );

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 32'd0;
        end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end else begin
            r_stall_count <= r_stall_count;
        end
    end

    assign bus.pc_en       = ~w_stall;
    assign bus.d_en        = ~w_stall;
    assign bus.e_flush     = w_stall;
    assign bus.md_busy     = w_md_busy;
    assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with default latencies.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   exp_cnt;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(
        .MULT_CYC (5),
        .DIV_CYC  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rs_D       = 5'd0;
        bus.rt_D       = 5'd0;
        bus.tuse_rs_D  = 2'd3;
        bus.tuse_rt_D  = 2'd3;
        bus.writereg_E = 5'd0;
        bus.writereg_M = 5'd0;
        bus.tnew_E     = 2'd0;
        bus.tnew_M     = 2'd0;
        bus.md_use_D   = 1'b0;
        bus.md_start_E = 1'b0;
        bus.md_div_E   = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        bus.md_start_E = 1'b1;
        step();
        step();
        reset = 1'b0;
        bus.md_start_E = 1'b0;
        step();
        #1;
        n_tests++;
        if (bus.pc_en !== 1'b1 || bus.d_en !== 1'b1 || bus.e_flush !== 1'b0) begin
            $display("FAIL reset_en: pc_en=%b d_en=%b e_flush=%b required 1 1 0",
                     bus.pc_en, bus.d_en, bus.e_flush);
            n_fail++;
        end
        n_tests++;
        if (bus.md_busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b required 0", bus.md_busy);
            n_fail++;
        end
        n_tests++;
        if (bus.stall_count !== 32'd0) begin
            $display("FAIL reset_count: got %0d required 0", bus.stall_count);
            n_fail++;
        end
        exp_cnt = 0;
    endtask

    task automatic test_load_use();
        bus.writereg_E = 5'd8;
        bus.tnew_E     = 2'd2;
        bus.rs_D       = 5'd8;
        bus.tuse_rs_D  = 2'd1;
        #1;
        n_tests++;
        if (bus.pc_en !== 1'b0 || bus.d_en !== 1'b0 || bus.e_flush !== 1'b1) begin
            $display("FAIL load_use_stall: pc_en=%b d_en=%b e_flush=%b required 0 0 1",
                     bus.pc_en, bus.d_en, bus.e_flush);
            n_fail++;
        end
        step();
        exp_cnt++;
        clear_inputs();
        #1;
        n_tests++;
        if (bus.pc_en !== 1'b1 || bus.stall_count !== 32'(exp_cnt)) begin
            $display("FAIL load_use_release: pc_en=%b count=%0d required 1 %0d",
                     bus.pc_en, bus.stall_count, exp_cnt);
            n_fail++;
        end
        // rt operand with tnew equal to tuse is forwardable, no stall
        bus.writereg_E = 5'd4;
        bus.tnew_E     = 2'd1;
        bus.rt_D       = 5'd4;
        bus.tuse_rt_D  = 2'd1;
        #1;
        n_tests++;
        if (bus.e_flush !== 1'b0) begin
            $display("FAIL e_rt_equal: e_flush=%b required 0", bus.e_flush);
            n_fail++;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_zero_reg();
        bus.writereg_E = 5'd0;
        bus.tnew_E     = 2'd2;
        bus.rs_D       = 5'd0;
        bus.tuse_rs_D  = 2'd0;
        bus.writereg_M = 5'd0;
        bus.tnew_M     = 2'd3;
        bus.rt_D       = 5'd0;
        bus.tuse_rt_D  = 2'd0;
        #1;
        n_tests++;
        if (bus.pc_en !== 1'b1 || bus.e_flush !== 1'b0) begin
            $display("FAIL zero_reg: pc_en=%b e_flush=%b required 1 0",
                     bus.pc_en, bus.e_flush);
            n_fail++;
        end
        step();
        n_tests++;
        if (bus.stall_count !== 32'(exp_cnt)) begin
            $display("FAIL zero_reg_count: got %0d required %0d", bus.stall_count, exp_cnt);
            n_fail++;
        end
        clear_inputs();
    endtask

    task automatic test_m_stage();
        bus.writereg_M = 5'd9;
        bus.tnew_M     = 2'd1;
        bus.rt_D       = 5'd9;
        bus.tuse_rt_D  = 2'd0;
        #1;
        n_tests++;
        if (bus.e_flush !== 1'b1 || bus.pc_en !== 1'b0) begin
            $display("FAIL m_stage_stall: e_flush=%b pc_en=%b required 1 0",
                     bus.e_flush, bus.pc_en);
            n_fail++;
        end
        bus.tuse_rt_D = 2'd1;
        #1;
        n_tests++;
        if (bus.e_flush !== 1'b0 || bus.pc_en !== 1'b1) begin
            $display("FAIL m_stage_nostall: e_flush=%b pc_en=%b required 0 1",
                     bus.e_flush, bus.pc_en);
            n_fail++;
        end
        // rs against M, then an operand marked unused
        bus.rt_D      = 5'd0;
        bus.rs_D      = 5'd9;
        bus.tnew_M    = 2'd2;
        bus.tuse_rs_D = 2'd1;
        #1;
        n_tests++;
        if (bus.e_flush !== 1'b1) begin
            $display("FAIL m_stage_rs: e_flush=%b required 1", bus.e_flush);
            n_fail++;
        end
        bus.tuse_rs_D = 2'd3;
        #1;
        n_tests++;
        if (bus.e_flush !== 1'b0) begin
            $display("FAIL tuse_none: e_flush=%b required 0", bus.e_flush);
            n_fail++;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_mult_mflo();
        bus.md_start_E = 1'b1;
        bus.md_div_E   = 1'b0;
        bus.md_use_D   = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            #1;
            n_tests++;
            if (bus.md_busy !== 1'b1 || bus.pc_en !== 1'b0 || bus.e_flush !== 1'b1) begin
                $display("FAIL mult_stall_t%0d: busy=%b pc_en=%b e_flush=%b required 1 0 1",
                         k, bus.md_busy, bus.pc_en, bus.e_flush);
                n_fail++;
            end
            step();
            exp_cnt++;
            bus.md_start_E = 1'b0;
        end
        #1;
        n_tests++;
        if (bus.md_busy !== 1'b0 || bus.pc_en !== 1'b1) begin
            $display("FAIL mult_release: busy=%b pc_en=%b required 0 1",
                     bus.md_busy, bus.pc_en);
            n_fail++;
        end
        n_tests++;
        if (bus.stall_count !== 32'(exp_cnt)) begin
            $display("FAIL mult_count: got %0d required %0d", bus.stall_count, exp_cnt);
            n_fail++;
        end
        clear_inputs();
        step();
    endtask

    task automatic test_restart_busy();
        bus.md_start_E = 1'b1;
        bus.md_div_E   = 1'b0;
        step();
        bus.md_start_E = 1'b0;
        step();
        bus.md_start_E = 1'b1;
        bus.md_div_E   = 1'b1;
        step();
        clear_inputs();
        step();
        step();
        #1;
        n_tests++;
        if (bus.md_busy !== 1'b1) begin
            $display("FAIL restart_t5: busy=%b required 1", bus.md_busy);
            n_fail++;
        end
        step();
        #1;
        n_tests++;
        if (bus.md_busy !== 1'b0 || bus.stall_count !== 32'(exp_cnt)) begin
            $display("FAIL restart_t6: busy=%b count=%0d required 0 %0d",
                     bus.md_busy, bus.stall_count, exp_cnt);
            n_fail++;
        end
    endtask

    task automatic test_data_and_start();
        bus.writereg_E = 5'd8;
        bus.tnew_E     = 2'd2;
        bus.rs_D       = 5'd8;
        bus.tuse_rs_D  = 2'd1;
        bus.md_start_E = 1'b1;
        #1;
        n_tests++;
        if (bus.e_flush !== 1'b1 || bus.md_busy !== 1'b1) begin
            $display("FAIL combo_start: e_flush=%b busy=%b required 1 1",
                     bus.e_flush, bus.md_busy);
            n_fail++;
        end
        step();
        exp_cnt++;
        clear_inputs();
        for (int k = 1; k <= 4; k++) step();
        #1;
        n_tests++;
        if (bus.md_busy !== 1'b1 || bus.e_flush !== 1'b0) begin
            $display("FAIL combo_t5: busy=%b e_flush=%b required 1 0",
                     bus.md_busy, bus.e_flush);
            n_fail++;
        end
        step();
        #1;
        n_tests++;
        if (bus.md_busy !== 1'b0 || bus.stall_count !== 32'(exp_cnt)) begin
            $display("FAIL combo_t6: busy=%b count=%0d required 0 %0d",
                     bus.md_busy, bus.stall_count, exp_cnt);
            n_fail++;
        end
    endtask

    task automatic test_div_length();
        bus.md_start_E = 1'b1;
        bus.md_div_E   = 1'b1;
        step();
        clear_inputs();
        for (int k = 1; k <= 9; k++) step();
        #1;
        n_tests++;
        if (bus.md_busy !== 1'b1) begin
            $display("FAIL div_t10: busy=%b required 1", bus.md_busy);
            n_fail++;
        end
        step();
        #1;
        n_tests++;
        if (bus.md_busy !== 1'b0) begin
            $display("FAIL div_t11: busy=%b required 0", bus.md_busy);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid_div();
        bus.md_start_E = 1'b1;
        bus.md_div_E   = 1'b1;
        bus.md_use_D   = 1'b1;
        step();
        exp_cnt++;
        bus.md_start_E = 1'b0;
        bus.md_div_E   = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            exp_cnt++;
        end
        #1;
        n_tests++;
        if (bus.md_busy !== 1'b1 || bus.stall_count !== 32'(exp_cnt)) begin
            $display("FAIL div_before_reset: busy=%b count=%0d required 1 %0d",
                     bus.md_busy, bus.stall_count, exp_cnt);
            n_fail++;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_cnt = 0;
        #1;
        n_tests++;
        if (bus.md_busy !== 1'b0 || bus.stall_count !== 32'd0 || bus.pc_en !== 1'b1) begin
            $display("FAIL div_after_reset: busy=%b count=%0d pc_en=%b required 0 0 1",
                     bus.md_busy, bus.stall_count, bus.pc_en);
            n_fail++;
        end
        clear_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_cnt = 0;
        reset   = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_zero_reg();
        test_m_stage();
        test_mult_mflo();
        test_restart_busy();
        test_data_and_start();
        test_div_length();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, meaning busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYC, default 10, meaning busy cycles for div/divu.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rs_D, rt_D  input  5 each  source registers of the D-stage instruction.
REQ-006 SHALL have port tuse_rs_D, tuse_rt_D  input  2 each  cycles until D instruction consumes the operand; 3 = not used.
REQ-007 SHALL have port writereg_E, writereg_M  input  5 each  destination register in E and M stages.
REQ-008 SHALL have port tnew_E, tnew_M  input  2 each  cycles until E/M result is available, as valid in that stage.
REQ-009 SHALL have port md_use_D  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have port md_start_E, md_div_E  input  1 each  E instruction starts the multiply/divide unit; md_div_E=1 selects divide.
REQ-011 SHALL have port pc_en, d_en  output  1 each  PC and F/D register write enables.
REQ-012 SHALL have port e_flush  output  1  clear D/E register to a bubble at the next edge.
REQ-013 SHALL have port md_busy  output  1  multiply/divide unit is occupied.
REQ-014 SHALL have port stall_count  output  32  saturating count of stalled cycles.

Function
REQ-015 SHALL assert data stall when rs_D!=0, rs_D==writereg_E, and tnew_E>tuse_rs_D; rt_D uses the same rule.
REQ-016 SHALL assert data stall when rs_D!=0, rs_D==writereg_M, and tnew_M>tuse_rs_D; rt_D uses the same rule.
REQ-017 SHALL never stall on register 0, regardless of tnew.
REQ-018 SHALL assert md stall when md_use_D=1 and md_busy=1.
REQ-019 SHALL drive stall = data stall OR md stall, combinationally in the same cycle.
REQ-020 SHALL drive pc_en = d_en = ~stall and e_flush = stall.
REQ-021 SHALL implement an FSM with states IDLE and BUSY plus a 4-bit down-counter cnt.
REQ-022 SHALL, in IDLE with md_start_E=1, load cnt with DIV_CYC when md_div_E=1 or MULT_CYC otherwise, and enter BUSY.
REQ-023 SHALL, in BUSY, decrement cnt each cycle and return to IDLE on the edge where cnt==1.
REQ-024 SHALL ignore md_start_E in BUSY, with no reload and no restart.
REQ-025 SHALL drive md_busy = (state==BUSY) OR md_start_E, so a D-stage md instruction stalls in the start cycle itself.
REQ-026 SHALL complete a mult started at cycle t with md_busy=1 for cycles t..t+MULT_CYC and 0 at t+MULT_CYC+1.
REQ-027 SHALL increment stall_count by 1 on every edge where stall=1 and hold it at 32'hFFFFFFFF at saturation.
REQ-028 SHALL, when a data stall and md_start_E occur together, start the timer, because the E instruction is valid and only the next D/E load is flushed.

Reset
REQ-029 SHALL, on reset=1 at an edge, set state=IDLE, cnt=0, stall_count=0, aborting any busy period mid-operation.
REQ-030 SHALL ignore md_start_E in the reset cycle.
REQ-031 SHALL, in the cycle after reset with zeroed inputs, output pc_en=1, d_en=1, e_flush=0, md_busy=0.

Structure
REQ-032 SHALL take the state enum (IDLE/BUSY), the TUSE/TNEW width (2), the TUSE_NONE=3 constant and the latency defaults from shared package pipe_ctrl_pkg.
REQ-033 SHALL place the FSM and counter in sub-module md_busy_timer (clk, reset, start, is_div -> busy); stall decode stays in the top module.

Verification
REQ-034 SHALL cover load-use: writereg_E=8, tnew_E=2, rs_D=8, tuse_rs_D=1 -> stall 1 cycle, e_flush=1, stall_count=1.
REQ-035 SHALL cover the zero register: writereg_E=0, tnew_E=2, rs_D=0, tuse_rs_D=0 -> pc_en=1, no stall.
REQ-036 SHALL cover M-stage hazard: writereg_M=9, tnew_M=1, rt_D=9, tuse_rt_D=0 -> stall; with tuse_rt_D=1 -> no stall.
REQ-037 SHALL cover mult followed by mflo: md_start_E=1, md_div_E=0 at t, md_use_D=1 held -> stall t..t+5, released at t+6.
REQ-038 SHALL cover reset mid-divide: div start, reset at cycle 4 -> next cycle md_busy=0, stall_count=0.
REQ-039 SHALL cover restart while busy: md_start_E pulsed during BUSY -> cnt unaffected, IDLE reached at original time.
